// File: rtl/fb_pkg.sv
// Framebuffer-wide types shared by the dither, scanout and SPRAM arbiter blocks.
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 14;
    localparam int unsigned FB_DATA_W = 16;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

    // Owner of the single SPRAM port in a given cycle.
    typedef enum logic [1:0] {
        PortIdle,
        PortRead,
        PortWrite,
        PortReset
    } fb_port_sel_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-buffer FIFO; full/empty are told apart by the extra pointer MSB.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH = FB_ADDR_W + FB_DATA_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_16mhz,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             push_en;
    logic             pop_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    // Storage needs no reset; occupancy is defined solely by the pointers.
    always_ff @(posedge clk_16mhz) begin
        if (push_en && !reset) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Single-port SPRAM arbiter: scanout reads issue immediately, dither writes are
// buffered and retired into cycles the scanout leaves idle.
module fb_sram_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_W     = 8,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_16mhz,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_status,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t    push_entry;
    wr_entry_t    head_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         drop;
    fb_port_sel_e port_sel;

    logic              rd_valid_q;
    logic              overflow_q;
    logic              overflow_d;
    logic [DROP_W-1:0] drop_count_q;
    logic [DROP_W-1:0] drop_count_d;

    assign push_entry = '{addr: wr_addr, data: wr_data};
    assign wr_ready   = !fifo_full && !reset;
    assign push       = wr_valid && wr_ready;
    assign drop       = wr_valid && !wr_ready && !reset;

    fb_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_16mhz (clk_16mhz),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        port_sel = PortIdle;
        if (reset) begin
            port_sel = PortReset;
        end else if (rd_req) begin
            port_sel = PortRead;
        end else if (!fifo_empty) begin
            port_sel = PortWrite;
        end
    end

    // Read address is the default so the idle port already tracks scanout.
    always_comb begin
        ram_addr = rd_addr;
        ram_wen  = 1'b0;
        pop      = 1'b0;
        case (port_sel)
            PortWrite: begin
                ram_addr = head_entry.addr;
                ram_wen  = 1'b1;
                pop      = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_wdata = head_entry.data;

    // SPRAM output is already registered, so read data passes straight through.
    assign rd_data  = ram_rdata;
    assign rd_valid = rd_valid_q;

    always_ff @(posedge clk_16mhz) begin
        rd_valid_q <= rd_req && !reset;
    end

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clr_status) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != {DROP_W{1'b1}}) begin
                drop_count_d = drop_count_q + {{(DROP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Scoreboard bench for fb_sram_arbiter: queue-based arbitration model predicts each
// SPRAM write and read return; a negedge monitor pops and compares them.
module tb_fb_sram_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int MSIZE = 16384;

    logic          clk_16mhz = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          clr_status;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic [7:0]    drop_count;

    always #5 clk_16mhz = ~clk_16mhz;

    fb_sram_arbiter dut (
        .clk_16mhz  (clk_16mhz),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clr_status (clr_status),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wen    (ram_wen),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Behavioural SPRAM with registered read port.
    logic [DW-1:0] spram [MSIZE];
    logic          mem_init;
    always @(posedge clk_16mhz) begin
        if (mem_init) begin
            for (int i = 0; i < MSIZE; i++) spram[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_wen) spram[ram_addr] <= ram_wdata;
            ram_rdata <= spram[ram_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          wr_exp[$];
    exp_t          rd_exp[$];
    ent_t          mq[$];
    logic [DW-1:0] gmem [MSIZE];
    bit            m_ovf;
    int            m_cnt;
    int            cyc;
    bit            mon_en;
    int            vectors;
    int            miscompares;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the expected response for this cycle, or checks the port stays quiet.
    always @(negedge clk_16mhz) begin
        exp_t e;
        if (mon_en) begin
            if (wr_exp.size() > 0 && wr_exp[0].cyc == cyc) begin
                e = wr_exp.pop_front();
                chk("ram_wen", {31'd0, ram_wen}, 32'd1);
                chk("ram_addr", {18'd0, ram_addr}, {18'd0, e.a});
                chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, e.d});
            end else begin
                chk("ram_wen_quiet", {31'd0, ram_wen}, 32'd0);
            end
            if (rd_exp.size() > 0 && rd_exp[0].cyc == cyc) begin
                e = rd_exp.pop_front();
                chk("rd_valid", {31'd0, rd_valid}, 32'd1);
                chk("rd_data", {16'd0, rd_data}, {16'd0, e.d});
            end else begin
                chk("rd_valid_quiet", {31'd0, rd_valid}, 32'd0);
            end
        end
    end

    task automatic step(input bit r, input bit rd, input logic [AW-1:0] ra, input bit wv,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit clr);
        bit exp_ready;
        bit retire;
        bit dropped;
        reset      = r;
        rd_req     = rd;
        rd_addr    = ra;
        wr_valid   = wv;
        wr_addr    = wa;
        wr_data    = wd;
        clr_status = clr;
        exp_ready  = (mq.size() < DEPTH) && !r;
        retire     = 1'b0;
        if (!r) begin
            if (rd) begin
                rd_exp.push_back('{cyc + 1, ra, gmem[ra]});
            end else if (mq.size() > 0) begin
                wr_exp.push_back('{cyc, mq[0].a, mq[0].d});
                gmem[mq[0].a] = mq[0].d;
                retire = 1'b1;
            end
        end
        @(negedge clk_16mhz);
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
        chk("fifo_level", {29'd0, fifo_level}, mq.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {24'd0, drop_count}, m_cnt);
        dropped = wv && !exp_ready && !r;
        if (r) begin
            mq.delete();
        end else begin
            if (retire) void'(mq.pop_front());
            if (wv && exp_ready) mq.push_back('{wa, wd});
        end
        if (r || clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (dropped) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk_16mhz);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        int bad;
        logic [AW-1:0] a;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        mon_en      = 0;
        m_ovf       = 0;
        m_cnt       = 0;
        for (int i = 0; i < MSIZE; i++) gmem[i] = '0;
        reset = 1; rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        clr_status = 0; mem_init = 1;
        @(posedge clk_16mhz);
        #1;
        mem_init = 0;
        mon_en   = 1;
        step(1, 0, '0, 0, '0, '0, 0);
        step(1, 0, '0, 1, 14'h0001, 16'h1111, 0);

        // Single write, no reads.
        step(0, 0, '0, 1, 14'h0123, 16'hA5A5, 0);
        idle(3);

        // Collision: read stream holds off a queued write.
        step(0, 0, '0, 1, 14'h0040, 16'hBEEF, 0);
        idle(2);
        step(0, 1, 14'h0040, 1, 14'h0200, 16'h1234, 0);
        step(0, 1, 14'h0040, 0, '0, '0, 0);
        step(0, 1, 14'h0040, 0, '0, '0, 0);
        idle(3);

        // Overflow: 6 writes against a blocked port.
        for (int i = 0; i < 6; i++)
            step(0, 1, 14'h0040, 1, 14'(16 + i), 16'($urandom), 0);
        idle(8);

        // Saturation, then a clear that coincides with a drop.
        for (int i = 0; i < 300; i++)
            step(0, 1, 14'($urandom_range(0, 63)), 1, 14'($urandom_range(0, 63)),
                 16'($urandom), 0);
        step(0, 1, 14'h0005, 1, 14'h0006, 16'h7777, 1);
        step(0, 0, '0, 0, '0, '0, 0);
        idle(6);

        // Scanout pattern: one read per 16 cycles, writes at ~50% duty.
        for (int i = 0; i < 480; i++)
            step(0, (i % 16) == 0, 14'($urandom_range(0, 63)), 1'($urandom % 2),
                 14'($urandom_range(0, 63)), 16'($urandom), 0);
        idle(6);

        // Random mix including occasional clear and reset.
        for (int i = 0; i < 600; i++)
            step(($urandom % 200) == 0, ($urandom % 4) == 0, 14'($urandom_range(0, 63)),
                 1'($urandom % 2), 14'($urandom_range(0, 63)), 16'($urandom),
                 ($urandom % 50) == 0);
        idle(6);

        // Reset with three queued writes: they must be discarded.
        for (int i = 0; i < 3; i++)
            step(0, 1, 14'h0010, 1, 14'(32 + i), 16'($urandom), 0);
        step(1, 0, '0, 1, 14'h0030, 16'hDEAD, 0);
        idle(10);

        mon_en = 0;
        bad = 0;
        for (int i = 0; i < MSIZE; i++) begin
            a = 14'(i);
            if (spram[a] !== gmem[a]) bad++;
        end
        chk("golden_image", bad, 0);
        chk("wr_exp_drained", wr_exp.size(), 0);
        chk("rd_exp_drained", rd_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
